// File: rtl/aes_pkg.sv
// Shared AES constants and byte-level helpers for the inverse-cipher datapath.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int BYTE_W  = 8;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [BYTE_W-1:0] inv_sbox(input logic [BYTE_W-1:0] b);
    return INV_SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_inv_mix_column.sv
// InvMixColumns on one 32-bit column: rows of the circulant matrix {0e 0b 0d 09}.
module aes_inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mul
      logic [7:0] x1, x2, x4, x8;
      assign x1 = col_in[31-8*gi -: 8];
      assign x2 = xtime(x1);
      assign x4 = xtime(x2);
      assign x8 = xtime(x4);
      assign m9[gi] = x8 ^ x1;
      assign mb[gi] = x8 ^ x2 ^ x1;
      assign md[gi] = x8 ^ x4 ^ x1;
      assign me[gi] = x8 ^ x4 ^ x2;
    end

    // Row r picks 0e for byte r, then 0b, 0d, 09 for the following bytes cyclically.
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign col_out[31-8*gi -: 8] = me[gi] ^ mb[(gi+1)%4] ^ md[(gi+2)%4] ^ m9[(gi+3)%4];
    end
  endgenerate

endmodule

// File: rtl/aes_inv_round.sv
// One AES-128 inverse round as a 3-stage valid/ready pipeline:
// InvShiftRows+InvSubBytes, AddRoundKey, optional InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
#(
  parameter bit SKIP_MIX_ALWAYS = 1'b0,
  parameter bit KEY_AT_INPUT    = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
  input  logic [STATE_W-1:0] key,
  input  logic               last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out
);

  logic               adv;
  logic [STATE_W-1:0] sub_bytes;
  logic [STATE_W-1:0] s1_data;
  logic [STATE_W-1:0] s2_data;
  logic [STATE_W-1:0] round_key;
  logic [STATE_W-1:0] mixed;
  logic               v1;
  logic               v2;
  logic               last_s1;
  logic               last_s2_q;
  logic               last_s2;

  // The whole pipeline moves as one; a held output freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  genvar gi;
  generate
    // Output byte 4c+r comes from input column (c-r) mod 4 of the same row.
    for (gi = 0; gi < 16; gi++) begin : g_sub
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
      assign sub_bytes[STATE_W-1-BYTE_W*gi -: BYTE_W] =
        inv_sbox(state_in[STATE_W-1-BYTE_W*SRC -: BYTE_W]);
    end

    if (KEY_AT_INPUT) begin : g_key_in
      logic [STATE_W-1:0] key_s1;
      always_ff @(posedge clk) begin
        if (adv) key_s1 <= key;
      end
      assign round_key = key_s1;
    end else begin : g_key_late
      assign round_key = key;
    end

    if (SKIP_MIX_ALWAYS) begin : g_final
      assign last_s2 = 1'b1;
    end else begin : g_any
      assign last_s2 = last_s2_q;
    end

    for (gi = 0; gi < 4; gi++) begin : g_mix
      aes_inv_mix_column u_mix (
        .col_in  (s2_data[STATE_W-1-32*gi -: 32]),
        .col_out (mixed[STATE_W-1-32*gi -: 32])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_data   <= sub_bytes;
      last_s1   <= last;
      s2_data   <= s1_data ^ round_key;
      last_s2_q <= last_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      state_out <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      state_out <= last_s2 ? s2_data : mixed;
    end
  end

endmodule
